// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment scanner.
package sev_seg_pkg;

  typedef enum logic [1:0] {
    TENS  = 2'd0,
    GAP_T = 2'd1,
    ONES  = 2'd2,
    GAP_O = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_ZERO  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ERR   = 7'b0000001;

  localparam int DIG_TENS = 1;
  localparam int DIG_ONES = 0;

  // Applies output polarity to an active-high segment pattern.
  function automatic logic [6:0] seg_drive(input logic [6:0] pat, input logic active_low);
    return pat ^ {7{active_low}};
  endfunction

endpackage

// File: rtl/sev_seg_mux_scan_phase_timer.sv
// Down-counter timing each scan phase: load (length-1) on entry, done when it reaches zero.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear beats load, load beats decrement; parks at zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/sev_seg_mux_scan.sv
// Two-digit time-multiplexed seven-segment scanner with per-frame input latching,
// inter-digit blanking and optional leading-zero suppression.
module sev_seg_mux_scan
  import sev_seg_pkg::*;
#(
  parameter int DWELL_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] tens,
  input  logic [6:0] ones,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic       frame_start
);

  localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_LEN < 1) ? 1 : $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (BLANK_CYCLES > 0);

  generate
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("sev_seg_mux_scan: DWELL_CYCLES must be >= 1");
    end
  endgenerate

  scan_state_t state_q, state_d;
  logic        idle_q, idle_d;
  logic [6:0]  shadow_tens_q, shadow_tens_d;
  logic [6:0]  shadow_ones_q, shadow_ones_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  dig_q, dig_d;
  logic        frame_start_q, frame_start_d;

  logic             capture_s;
  logic             tmr_clr_s;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_done_s;
  logic [6:0]       seg_pat_s;
  logic [1:0]       dig_on_s;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr_s),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // Scan sequencing. idle_q marks a fresh GAP_O entry (reset or en low) so the
  // first frame_start lands BLANK_CYCLES+1 cycles after restart.
  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    capture_s  = 1'b0;
    tmr_clr_s  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    if (!en) begin
      state_d   = GAP_O;
      idle_d    = 1'b1;
      tmr_clr_s = 1'b1;
    end else if (idle_q) begin
      idle_d     = 1'b0;
      tmr_load_s = 1'b1;
      if (HAS_GAP) begin
        tmr_val_s = BLANK_LD;
      end else begin
        state_d   = TENS;
        capture_s = 1'b1;
        tmr_val_s = DWELL_LD;
      end
    end else if (tmr_done_s) begin
      tmr_load_s = 1'b1;
      case (state_q)
        TENS: begin
          if (HAS_GAP) begin
            state_d   = GAP_T;
            tmr_val_s = BLANK_LD;
          end else begin
            state_d   = ONES;
            tmr_val_s = DWELL_LD;
          end
        end
        GAP_T: begin
          state_d   = ONES;
          tmr_val_s = DWELL_LD;
        end
        ONES: begin
          if (HAS_GAP) begin
            state_d   = GAP_O;
            tmr_val_s = BLANK_LD;
          end else begin
            state_d   = TENS;
            capture_s = 1'b1;
            tmr_val_s = DWELL_LD;
          end
        end
        GAP_O: begin
          state_d   = TENS;
          capture_s = 1'b1;
          tmr_val_s = DWELL_LD;
        end
        default: begin
          state_d    = GAP_O;
          idle_d     = 1'b1;
          tmr_load_s = 1'b0;
          tmr_clr_s  = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Shadow registers only change at frame start, so a frame never tears.
  always_comb begin
    if (capture_s) begin
      shadow_tens_d = tens;
      shadow_ones_d = ones;
    end else begin
      shadow_tens_d = shadow_tens_q;
      shadow_ones_d = shadow_ones_q;
    end
  end

  // Output decode from next state so outputs move in lockstep with the state.
  always_comb begin
    seg_pat_s = SEG_BLANK;
    dig_on_s  = 2'b00;
    case (state_d)
      TENS: begin
        if (LZ_BLANK && (shadow_tens_d == SEG_ZERO)) begin
          seg_pat_s = SEG_BLANK;
          dig_on_s  = 2'b00;
        end else begin
          seg_pat_s          = shadow_tens_d;
          dig_on_s[DIG_TENS] = 1'b1;
        end
      end
      ONES: begin
        seg_pat_s          = shadow_ones_d;
        dig_on_s[DIG_ONES] = 1'b1;
      end
      GAP_T, GAP_O: begin
        seg_pat_s = SEG_BLANK;
        dig_on_s  = 2'b00;
      end
      default: begin
        seg_pat_s = SEG_BLANK;
        dig_on_s  = 2'b00;
      end
    endcase
    seg_d         = seg_drive(seg_pat_s, SEG_ACTIVE_LOW);
    dig_d         = dig_on_s ^ {2{DIG_ACTIVE_LOW}};
    frame_start_d = capture_s;
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= GAP_O;
      idle_q        <= 1'b1;
      shadow_tens_q <= 7'b0000000;
      shadow_ones_q <= 7'b0000000;
      seg_q         <= seg_drive(SEG_BLANK, SEG_ACTIVE_LOW);
      dig_q         <= {2{DIG_ACTIVE_LOW}};
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_q        <= idle_d;
      shadow_tens_q <= shadow_tens_d;
      shadow_ones_q <= shadow_ones_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dig         = dig_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sev_seg_mux_scan.sv
// Self-checking bench: three scanner configurations against a frame-arithmetic reference model.
module tb_sev_seg_mux_scan;
  import sev_seg_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [6:0] tens = 7'b0000000;
  logic [6:0] ones = 7'b0000000;
  logic [6:0] seg_o [3];
  logic [1:0] dig_o [3];
  logic       fs_o  [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Inst 0: BLANK=2 LZ on; inst 1: BLANK=2 LZ off; inst 2: BLANK=0 LZ on.
  sev_seg_mux_scan #(.DWELL_CYCLES(D), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0),
                     .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) u_lz (
    .clk(clk), .rst_n(rst_n), .en(en), .tens(tens), .ones(ones),
    .seg(seg_o[0]), .dig(dig_o[0]), .frame_start(fs_o[0]));
  sev_seg_mux_scan #(.DWELL_CYCLES(D), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0),
                     .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) u_nolz (
    .clk(clk), .rst_n(rst_n), .en(en), .tens(tens), .ones(ones),
    .seg(seg_o[1]), .dig(dig_o[1]), .frame_start(fs_o[1]));
  sev_seg_mux_scan #(.DWELL_CYCLES(D), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0),
                     .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) u_nogap (
    .clk(clk), .rst_n(rst_n), .en(en), .tens(tens), .ones(ones),
    .seg(seg_o[2]), .dig(dig_o[2]), .frame_start(fs_o[2]));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int blank_of(input int i);
    return (i == 2) ? 0 : 2;
  endfunction

  function automatic bit lz_of(input int i);
    return (i != 1);
  endfunction

  // Phase n cycles after (re)start: 0 = dark, 1 = tens lit, 2 = ones lit.
  function automatic int phase_at(input int i, input int n);
    int b;
    int k;
    b = blank_of(i);
    if (n <= b) return 0;
    k = (n - b - 1) % (2 * (D + b));
    if (k < D) return 1;
    if (k >= D + b && k < 2 * D + b) return 2;
    return 0;
  endfunction

  function automatic bit fs_at(input int i, input int n);
    int b;
    b = blank_of(i);
    return (n > b) && (((n - b - 1) % (2 * (D + b))) == 0);
  endfunction

  function automatic logic [6:0] exp_seg(input int i, input int ph, input logic [6:0] t,
                                         input logic [6:0] o);
    if (ph == 1) return (lz_of(i) && t == SEG_ZERO) ? 7'b0000000 : t;
    if (ph == 2) return o;
    return 7'b0000000;
  endfunction

  function automatic logic [1:0] exp_dig(input int i, input int ph, input logic [6:0] t);
    if (ph == 1) return (lz_of(i) && t == SEG_ZERO) ? 2'b11 : 2'b01;
    if (ph == 2) return 2'b10;
    return 2'b11;
  endfunction

  int         m_n   [3];
  logic [6:0] m_t   [3];
  logic [6:0] m_o   [3];
  logic [6:0] e_seg [3];
  logic [1:0] e_dig [3];
  logic       e_fs  [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_n[i] <= 0;  m_t[i] <= 7'b0000000;  m_o[i] <= 7'b0000000;
        e_seg[i] <= 7'b0000000;  e_dig[i] <= 2'b11;  e_fs[i] <= 1'b0;
      end else if (!en) begin
        m_n[i] <= 0;
        e_seg[i] <= 7'b0000000;  e_dig[i] <= 2'b11;  e_fs[i] <= 1'b0;
      end else begin
        m_n[i] <= m_n[i] + 1;
        e_fs[i] <= fs_at(i, m_n[i] + 1);
        if (fs_at(i, m_n[i] + 1)) begin
          m_t[i] <= tens;
          m_o[i] <= ones;
          e_seg[i] <= exp_seg(i, phase_at(i, m_n[i] + 1), tens, ones);
          e_dig[i] <= exp_dig(i, phase_at(i, m_n[i] + 1), tens);
        end else begin
          e_seg[i] <= exp_seg(i, phase_at(i, m_n[i] + 1), m_t[i], m_o[i]);
          e_dig[i] <= exp_dig(i, phase_at(i, m_n[i] + 1), m_t[i]);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;  en = 1'b1;  tens = 7'b0110000;  ones = 7'b1011011;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (seg_o[i] !== 7'b0000000 || dig_o[i] !== 2'b11 || fs_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: seg=%b dig=%b fs=%b, want 0000000 11 0",
                 i, seg_o[i], dig_o[i], fs_o[i]);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (c < 3 && (seg_o[0] !== 7'b0000000 || dig_o[0] !== 2'b11 || fs_o[0] !== 1'b0)) begin
        n_fail++;
        $display("FAIL reset_release c%0d: seg=%b dig=%b fs=%b, want dark", c, seg_o[0], dig_o[0], fs_o[0]);
      end else if (c == 3 && (seg_o[0] !== 7'b0110000 || dig_o[0] !== 2'b01 || fs_o[0] !== 1'b1)) begin
        n_fail++;
        $display("FAIL first_frame: seg=%b dig=%b fs=%b, want 0110000 01 1", seg_o[0], dig_o[0], fs_o[0]);
      end
      n_checks++;
      if (fs_o[2] !== (c == 1)) begin
        n_fail++;
        $display("FAIL nogap_first_fs c%0d: fs=%b want %b", c, fs_o[2], (c == 1));
      end
    end
  endtask

  task automatic test_scan;
    int last0 = -1;
    int last2 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seg_o[i] !== e_seg[i] || dig_o[i] !== e_dig[i] || fs_o[i] !== e_fs[i]) begin
          n_fail++;
          $display("FAIL scan inst%0d: seg=%b dig=%b fs=%b, want %b %b %b",
                   i, seg_o[i], dig_o[i], fs_o[i], e_seg[i], e_dig[i], e_fs[i]);
        end
      end
      if (fs_o[0] === 1'b1) begin
        if (last0 >= 0) begin
          n_checks++;
          if (c - last0 != 12) begin
            n_fail++;
            $display("FAIL period_gap: got %0d cycles, want 12", c - last0);
          end
        end
        last0 = c;
      end
      if (fs_o[2] === 1'b1) begin
        if (last2 >= 0) begin
          n_checks++;
          if (c - last2 != 8) begin
            n_fail++;
            $display("FAIL period_nogap: got %0d cycles, want 8", c - last2);
          end
        end
        last2 = c;
      end
    end
  endtask

  task automatic test_shadow;
    int guard = 0;
    ones = 7'b1011011;
    do begin @(negedge clk); guard++; end while (fs_o[0] !== 1'b1 && guard < 40);
    n_checks++;
    if (fs_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL shadow_wait_fs: fs=%b want 1 within 40 cycles", fs_o[0]);
    end
    for (int idx = 1; idx <= 20; idx++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seg_o[i] !== e_seg[i] || dig_o[i] !== e_dig[i] || fs_o[i] !== e_fs[i]) begin
          n_fail++;
          $display("FAIL shadow inst%0d idx%0d: seg=%b dig=%b fs=%b, want %b %b %b",
                   i, idx, seg_o[i], dig_o[i], fs_o[i], e_seg[i], e_dig[i], e_fs[i]);
        end
      end
      if (idx == 8 || idx == 9) begin
        n_checks++;
        if (seg_o[0] !== 7'b1011011) begin
          n_fail++;
          $display("FAIL shadow_hold idx%0d: seg=%b want 1011011", idx, seg_o[0]);
        end
      end
      if (idx == 18) begin
        n_checks++;
        if (seg_o[0] !== 7'b1111111 || dig_o[0] !== 2'b10) begin
          n_fail++;
          $display("FAIL shadow_update: seg=%b dig=%b want 1111111 10", seg_o[0], dig_o[0]);
        end
      end
      if (idx == 7) ones = 7'b1111111;
    end
  endtask

  task automatic test_lz;
    int guard = 0;
    tens = SEG_ZERO;
    do begin @(negedge clk); guard++; end while (fs_o[0] !== 1'b1 && guard < 40);
    n_checks++;
    if (seg_o[0] !== 7'b0000000 || dig_o[0] !== 2'b11) begin
      n_fail++;
      $display("FAIL lz_on: seg=%b dig=%b want 0000000 11", seg_o[0], dig_o[0]);
    end
    n_checks++;
    if (seg_o[1] !== 7'b1111110 || dig_o[1] !== 2'b01) begin
      n_fail++;
      $display("FAIL lz_off: seg=%b dig=%b want 1111110 01", seg_o[1], dig_o[1]);
    end
    guard = 0;
    do begin @(negedge clk); guard++; end while (fs_o[0] !== 1'b1 && guard < 40);
    n_checks++;
    if (guard != 12 || fs_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL lz_period: got %0d cycles (inst1 fs=%b), want 12 and 1", guard, fs_o[1]);
    end
  endtask

  task automatic test_en;
    int guard = 0;
    tens = 7'b0110000;
    do begin @(negedge clk); guard++; end while (fs_o[0] !== 1'b1 && guard < 40);
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seg_o[i] !== 7'b0000000 || dig_o[i] !== 2'b11 || fs_o[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL en_low inst%0d c%0d: seg=%b dig=%b fs=%b, want dark", i, c, seg_o[i], dig_o[i], fs_o[i]);
        end
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (fs_o[0] !== (k == 3) || fs_o[2] !== (k == 1)) begin
        n_fail++;
        $display("FAIL en_rise k%0d: fs0=%b fs2=%b want %b %b", k, fs_o[0], fs_o[2], (k == 3), (k == 1));
      end
    end
  endtask

  task automatic test_random;
    logic [6:0] pick;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seg_o[i] !== e_seg[i] || dig_o[i] !== e_dig[i] || fs_o[i] !== e_fs[i]) begin
          n_fail++;
          $display("FAIL random inst%0d c%0d: seg=%b dig=%b fs=%b, want %b %b %b",
                   i, c, seg_o[i], dig_o[i], fs_o[i], e_seg[i], e_dig[i], e_fs[i]);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: pick = SEG_ZERO;
          1: pick = SEG_ERR;
          default: pick = 7'($urandom);
        endcase
        tens = pick;
        ones = 7'($urandom);
      end
      en = ($urandom_range(0, 59) != 0);
    end
    en = 1'b1;
  endtask

  task automatic test_async;
    int guard = 0;
    tens = 7'b0110000;  ones = 7'b1011011;
    do begin @(negedge clk); guard++; end while (fs_o[2] !== 1'b1 && guard < 40);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (seg_o[i] !== 7'b0000000 || dig_o[i] !== 2'b11 || fs_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset inst%0d: seg=%b dig=%b fs=%b, want dark", i, seg_o[i], dig_o[i], fs_o[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (seg_o[i] !== e_seg[i] || dig_o[i] !== e_dig[i] || fs_o[i] !== e_fs[i]) begin
          n_fail++;
          $display("FAIL post_async inst%0d c%0d: seg=%b dig=%b fs=%b, want %b %b %b",
                   i, c, seg_o[i], dig_o[i], fs_o[i], e_seg[i], e_dig[i], e_fs[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_shadow();
    test_lz();
    test_en();
    test_random();
    test_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
